// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
// cdb_arbiter_pkg : shared types and constants for the CDB arbiter slice
// Revision: 1.0
// ============================================================================
`default_nettype none

package cdb_arbiter_pkg;

  localparam int c_ROB_TAG_W = 4;
  localparam int c_PRD_W     = 6;
  localparam int c_N_REQ     = 3;

  localparam int c_REQ_ALU = 0;
  localparam int c_REQ_BRU = 1;
  localparam int c_REQ_LSU = 2;

  typedef struct packed {
    logic [c_ROB_TAG_W-1:0] rob_tag;
    logic [c_PRD_W-1:0]     prd;
    logic                   rd_used;
    logic [31:0]            data;
    logic                   br_mispredict;
    logic [31:0]            br_target;
  } cdb_pkt_t;

endpackage

`default_nettype wire

// File: rtl/cdb_age_select.sv
// ============================================================================
// cdb_age_select : one-hot grant of the oldest occupied slot relative to the
//                  ROB head; ties resolve to the lowest index
// Revision: 1.0
// ============================================================================
`default_nettype none

module cdb_age_select #(
  parameter int N_REQ     = 3,
  parameter int ROB_TAG_W = 4
) (
  input  logic [N_REQ-1:0]                slot_v_i,
  input  logic [N_REQ-1:0][ROB_TAG_W-1:0] slot_tag_i,
  input  logic [ROB_TAG_W-1:0]            rob_head_i,
  output logic [N_REQ-1:0]                grant_o
);

  logic [ROB_TAG_W-1:0] w_age;
  logic [ROB_TAG_W-1:0] w_best;
  logic                 w_found;

  always_comb begin
    grant_o = '0;
    w_age   = '0;
    w_best  = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      // Modular distance from the head; strict compare keeps the lower index on ties
      w_age = slot_tag_i[i] - rob_head_i;
      if (slot_v_i[i] && (!w_found || (w_age < w_best))) begin
        w_found    = 1'b1;
        w_best     = w_age;
        grant_o    = '0;
        grant_o[i] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter : per-requester holding slots, oldest-first CDB arbitration,
//               registered CDB broadcast and saturating conflict counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ     = c_N_REQ,
  parameter int ROB_TAG_W = c_ROB_TAG_W,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [ROB_TAG_W-1:0]       rob_head_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  cdb_pkt_t [N_REQ-1:0]       req_pkt_i,
  output logic                       cdb_valid_o,
  output cdb_pkt_t                   cdb_pkt_o,
  output logic [N_REQ-1:0]           cdb_grant_o,
  output logic [CNT_W-1:0]           conflict_cnt_o
);

  localparam int c_OCC_W = $clog2(N_REQ + 1);

  logic [N_REQ-1:0]                r_slot_v;
  cdb_pkt_t [N_REQ-1:0]            r_slot_pkt;
  logic [N_REQ-1:0][ROB_TAG_W-1:0] w_slot_tag;
  logic [N_REQ-1:0]                w_grant;
  logic [N_REQ-1:0]                w_load;
  cdb_pkt_t                        w_win_pkt;
  logic [c_OCC_W-1:0]              w_occ;

  logic                            r_cdb_valid;
  cdb_pkt_t                        r_cdb_pkt;
  logic [N_REQ-1:0]                r_cdb_grant;
  logic [CNT_W-1:0]                r_conflict_cnt;

  for (genvar i = 0; i < N_REQ; i++) begin : g_tag
    assign w_slot_tag[i] = r_slot_pkt[i].rob_tag;
  end

  cdb_age_select #(
    .N_REQ     (N_REQ),
    .ROB_TAG_W (ROB_TAG_W)
  ) u_age_select (
    .slot_v_i   (r_slot_v),
    .slot_tag_i (w_slot_tag),
    .rob_head_i (rob_head_i),
    .grant_o    (w_grant)
  );

  // A slot being drained this cycle can accept a new result at the same edge
  assign req_ready_o = {N_REQ{!flush_i}} & (~r_slot_v | w_grant);
  assign w_load      = req_valid_i & req_ready_o;

  always_comb begin
    w_win_pkt = '0;
    w_occ     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_win_pkt = r_slot_pkt[i];
      w_occ = w_occ + c_OCC_W'(r_slot_v[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_v   <= '0;
      r_slot_pkt <= '0;
    end else if (flush_i) begin
      r_slot_v <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_load[i]) begin
          r_slot_v[i]   <= 1'b1;
          r_slot_pkt[i] <= req_pkt_i[i];
        end else if (w_grant[i]) begin
          r_slot_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_valid <= 1'b0;
      r_cdb_pkt   <= '0;
      r_cdb_grant <= '0;
    end else if (flush_i) begin
      r_cdb_valid <= 1'b0;
      r_cdb_grant <= '0;
    end else begin
      r_cdb_valid <= |w_grant;
      r_cdb_grant <= w_grant;
      if (|w_grant) r_cdb_pkt <= w_win_pkt;
    end
  end

  // Flush does not clear the counter; it is a performance statistic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if ((w_occ >= c_OCC_W'(2)) && !(&r_conflict_cnt)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign cdb_valid_o    = r_cdb_valid;
  assign cdb_pkt_o      = r_cdb_pkt;
  assign cdb_grant_o    = r_cdb_grant;
  assign conflict_cnt_o = r_conflict_cnt;

endmodule

`default_nettype wire
